// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy count
// and programmable almost-full / almost-empty flags.
// Optional build macro SYNC_FIFO_ERR_EN adds sticky overflow/underflow ports.
module sync_fifo #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned ENTRIES      = 16,
  parameter int unsigned AFULL_LEVEL  = 12,
  parameter int unsigned AEMPTY_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wput,
  output logic                       full,
  output logic                       almost_full,
  output logic [WIDTH-1:0]           dout,
  input  logic                       rget,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(ENTRIES):0]   count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int unsigned AW = $clog2(ENTRIES);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             push;
  logic             pop;

  // Status flags come from registered pointers only; the wrap bit separates full from empty
  always_comb begin
    empty        = (wptr_q == rptr_q);
    full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    almost_full  = (count_q >= PW'(AFULL_LEVEL));
    almost_empty = (count_q <= PW'(AEMPTY_LEVEL));
    count        = count_q;
    dout         = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  // Request acceptance against pre-edge flags, next pointer and count values
  always_comb begin
    push    = wput && !full;
    pop     = rget && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents survive reset, write suppressed while in reset
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q[AW-1:0]] <= din;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error capture for rejected requests
  always_comb begin
    overflow_d  = overflow_q  || (wput && full);
    underflow_d = underflow_q || (rget && empty);
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

  // Error flag registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif

endmodule
